// File: rtl/flit_link_tx.sv
// flit_link_tx: drains the per-port flit FIFO onto the inter-router link.
// Credits are taken when a read is issued, so each flit in flight already owns
// its downstream slot. The read-to-link path has a fixed 2-cycle latency.
module flit_link_tx #(
  parameter int CREDITS = 8,
  parameter int CW      = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [3:0]    fifo_count,
  output logic          fifo_read,
  input  logic [7:0]    fifo_data,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          credit_in,
  output logic [CW-1:0] credits,
  output logic          credit_err,
  output logic [7:0]    flit_cnt,
  output logic          busy
);
  localparam int            STAGES = 2;
  localparam logic [CW-1:0] CMAX   = CW'(CREDITS);

  // vld_pipe[1] = rd_v (FIFO data arrives this cycle), vld_pipe[STAGES] = tx_valid
  logic [STAGES:1] vld_pipe;

  // rst is folded in so no read strobe escapes while reset is held
  assign fifo_read = rst & enable & (fifo_count != 4'd0) & (credits != '0);
  assign tx_valid  = vld_pipe[STAGES];
  assign busy      = |vld_pipe;

  // valid shift register: one bit per flit from read issue to link
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_pipe <= '0;
    else      vld_pipe <= {vld_pipe[STAGES-1:1], fifo_read};
  end

  // capture FIFO output onto the link and count transmitted flits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_data  <= 8'h00;
      flit_cnt <= 8'h00;
    end else if (vld_pipe[STAGES-1]) begin
      tx_data  <= fifo_data;
      flit_cnt <= flit_cnt + 8'd1;
    end
  end

  // credit counter; a return with no read while full is an overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits    <= CMAX;
      credit_err <= 1'b0;
    end else begin
      case ({fifo_read, credit_in})
        2'b10: credits <= credits - 1'b1;
        2'b01: begin
          if (credits == CMAX) credit_err <= 1'b1;
          else                 credits    <= credits + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_flit_link_tx.sv
// tb_flit_link_tx: random and directed traffic against a scheduled-delivery
// model: each predicted read owes the link one flit two cycles later, and
// credits are tracked as a plain running balance.
module tb_flit_link_tx;
  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] fifo_count;
  logic       fifo_read;
  logic [7:0] fifo_data;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       credit_in;
  logic [3:0] credits;
  logic       credit_err;
  logic [7:0] flit_cnt;
  logic       busy;

  flit_link_tx dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_count(fifo_count),
    .fifo_read(fifo_read), .fifo_data(fifo_data), .tx_data(tx_data),
    .tx_valid(tx_valid), .credit_in(credit_in), .credits(credits),
    .credit_err(credit_err), .flit_cnt(flit_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int due; logic [7:0] d;} fl_t;

  logic [7:0] env_q[$];   // upstream FIFO contents as the DUT sees them
  logic [7:0] m_q[$];     // same contents as the model expects to drain them
  fl_t        pend[$];    // flits owed to the link, with the cycle they are due
  int         m_cred, m_err, m_cnt, cyc;
  logic [7:0] m_txd;
  int         n_pass = 0, n_tot = 0;
  logic       rd_s;

  task automatic chk(input string tag, input int got, input int exp);
    n_tot++;
    if (got !== exp) $display("FAIL %s cyc=%0d: got %0d expected %0d", tag, cyc, got, exp);
    else n_pass++;
  endtask

  task automatic push(input logic [7:0] d);
    env_q.push_back(d);
    m_q.push_back(d);
  endtask

  // one clock: check at the falling edge, advance model, then let the FIFO respond
  task automatic tick();
    logic exp_rd, exp_v, exp_busy;
    fifo_count = (env_q.size() > 8) ? 4'd8 : 4'(env_q.size());
    @(negedge clk);
    if (!rst) begin
      m_cred = 8; m_err = 0; m_cnt = 0; m_txd = 8'h00;
      pend.delete();
    end
    exp_rd   = rst && enable && (fifo_count != 0) && (m_cred != 0);
    exp_v    = (pend.size() > 0) && (pend[0].due == cyc);
    exp_busy = 1'b0;
    foreach (pend[i]) if (pend[i].due == cyc || pend[i].due == cyc + 1) exp_busy = 1'b1;
    if (exp_v) begin
      m_txd = pend[0].d;
      m_cnt = (m_cnt + 1) % 256;
      void'(pend.pop_front());
    end
    chk("fifo_read",  int'(fifo_read),  int'(exp_rd));
    chk("tx_valid",   int'(tx_valid),   int'(exp_v));
    chk("tx_data",    int'(tx_data),    int'(m_txd));
    chk("credits",    int'(credits),    m_cred);
    chk("credit_err", int'(credit_err), m_err);
    chk("flit_cnt",   int'(flit_cnt),   m_cnt);
    chk("busy",       int'(busy),       int'(exp_busy));
    if (rst) begin
      if (exp_rd) pend.push_back('{cyc + 2, (m_q.size() > 0) ? m_q.pop_front() : 8'h00});
      if (credit_in && !exp_rd && m_cred == 8) m_err = 1;
      else m_cred = m_cred + int'(credit_in) - int'(exp_rd);
    end
    rd_s = fifo_read;
    cyc++;
    @(posedge clk);
    #1;
    if (rd_s && env_q.size() > 0) fifo_data = env_q.pop_front();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    cyc = 0; m_cred = 8; m_err = 0; m_cnt = 0; m_txd = 8'h00;
    rst = 1'b0; enable = 1'b1; credit_in = 1'b0; fifo_data = 8'h00;
    // reset held with data waiting: no reads, reset values
    for (int i = 0; i < 5; i++) push(8'(8'hA0 + i));
    ticks(3);
    rst = 1'b1;
    ticks(8);
    credit_in = 1'b1; ticks(5); credit_in = 1'b0;
    // three-flit burst
    push(8'h11); push(8'h22); push(8'h33);
    ticks(6);
    credit_in = 1'b1; ticks(3); credit_in = 1'b0;
    // credit exhaustion, then a single returned credit
    for (int i = 0; i < 12; i++) push(8'(8'h40 + i));
    ticks(11);
    credit_in = 1'b1; tick(); credit_in = 1'b0;
    ticks(4);
    // return four credits, then read and return together (credits stays 4)
    enable = 1'b0; credit_in = 1'b1; ticks(4);
    enable = 1'b1; ticks(3);
    credit_in = 1'b0; enable = 1'b0; ticks(2);
    // refill to full then overflow; error must stick through traffic
    credit_in = 1'b1; ticks(10); credit_in = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) push(8'(8'hC0 + i));
    ticks(8);
    // full credits with read and return together: no error after reset
    rst = 1'b0; tick(); rst = 1'b1;
    push(8'h5A); credit_in = 1'b1; tick(); credit_in = 1'b0; ticks(3);
    // reset in the cycle after a read: flit dropped
    push(8'h77); tick();
    rst = 1'b0; tick(); rst = 1'b1;
    env_q.delete(); m_q.delete();
    ticks(3);
    // 256+ flit stream with a credit back every cycle: flit_cnt wraps
    for (int i = 0; i < 260; i++) push(8'(i * 7));
    credit_in = 1'b1;
    for (int i = 0; i < 270; i++) begin
      if (env_q.size() > 0 && env_q.size() < 4) credit_in = 1'b1;
      tick();
    end
    credit_in = 1'b0;
    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      enable    = ($urandom_range(0, 9) != 0);
      credit_in = ($urandom_range(0, 9) < 4);
      rst       = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 1) == 1 && env_q.size() < 12) push(8'($urandom));
      tick();
    end
    rst = 1'b1; credit_in = 1'b0; ticks(4);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
